// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the DVP camera capture front end.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        StWaitVs,
        StSkip,
        StActive
    } cap_state_e;

    // RGB565 field positions within a 16-bit pixel
    localparam int unsigned RGB_R_MSB = 15;
    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_G_MSB = 10;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_B_MSB = 4;
    localparam int unsigned RGB_B_LSB = 0;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/dvp_edge_sync.sv
// Registers the DVP bus once and flags VSYNC/HREF edges against a delayed copy.
module dvp_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       href,
    output logic [7:0] data,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_fall
);

    logic       vsync_q;
    logic       vsync_qq;
    logic       href_q;
    logic       href_qq;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            vsync_q  <= cam_vsync;
            vsync_qq <= vsync_q;
            href_q   <= cam_href;
            href_qq  <= href_q;
            data_q   <= cam_data;
        end
    end

    assign href       = href_q;
    assign data       = data_q;
    assign vsync_rise = vsync_q & ~vsync_qq;
    assign vsync_fall = ~vsync_q & vsync_qq;
    assign href_fall  = ~href_q & href_qq;

endmodule

// File: rtl/camera_pixel_capture.sv
// DVP byte-pair to RGB565 pixel capture with frame skipping, coordinates and
// per-frame integrity status.
module camera_pixel_capture
    import cam_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEFAULT,
    parameter int unsigned SKIP_FRAMES = 2,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           cam_vsync,
    input  logic           cam_href,
    input  logic [7:0]     cam_data,
    output logic [15:0]    pixel_out,
    output logic           data_valid_out,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           frame_start,
    output logic           frame_done,
    output logic           frame_error,
    output logic [15:0]    frame_count
);

    // Counters carry one extra bit so they can hold H_ACTIVE / V_ACTIVE exactly
    localparam logic [X_W:0] H_MAX     = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W:0] V_MAX     = (Y_W + 1)'(V_ACTIVE);
    localparam logic [7:0]   SKIP_INIT = 8'(SKIP_FRAMES);

    logic       href_q;
    logic [7:0] data_q;
    logic       vsync_rise;
    logic       vsync_fall;
    logic       href_fall;
    logic       line_end;

    cap_state_e     state_q, state_d;
    logic [7:0]     skip_q, skip_d;
    logic [X_W:0]   col_q, col_d;
    logic [Y_W:0]   row_q, row_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic           err_q, err_d;
    logic           first_q, first_d;
    logic           enable_q;

    logic [15:0]    pix_d;
    logic           dv_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           fs_d;
    logic           fd_d;
    logic           fe_d;
    logic [15:0]    fc_d;

    dvp_edge_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .href       (href_q),
        .data       (data_q),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

    // A frame ending with HREF still high closes the line in the same cycle
    assign line_end = href_fall | (vsync_rise & href_q);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        err_d   = err_q;
        first_d = first_q;
        pix_d   = pixel_out;
        dv_d    = 1'b0;
        x_d     = x_out;
        y_d     = y_out;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        fe_d    = frame_error;
        fc_d    = frame_count;

        unique case (state_q)
            StWaitVs: begin
                if (vsync_fall && enable) begin
                    if (skip_q != 8'd0) begin
                        state_d = StSkip;
                    end else begin
                        state_d = StActive;
                        col_d   = '0;
                        row_d   = '0;
                        phase_d = 1'b0;
                        err_d   = 1'b0;
                        first_d = 1'b1;
                    end
                end
            end
            StSkip: begin
                if (vsync_rise) begin
                    skip_d  = skip_q - 8'd1;
                    state_d = StWaitVs;
                end
            end
            StActive: begin
                if (href_q && !vsync_rise) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < H_MAX && row_q < V_MAX) begin
                            pix_d   = {hi_q, data_q};
                            dv_d    = 1'b1;
                            x_d     = col_q[X_W-1:0];
                            y_d     = row_q[Y_W-1:0];
                            fs_d    = first_q;
                            first_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (col_q < H_MAX) begin
                            col_d = col_q + (X_W + 1)'(1);
                        end
                    end
                end
                if (line_end) begin
                    if (phase_q || col_q != H_MAX) begin
                        err_d = 1'b1;
                    end
                    if (col_q != '0 && row_q < V_MAX) begin
                        row_d = row_q + (Y_W + 1)'(1);
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                end
                if (vsync_rise) begin
                    fd_d    = 1'b1;
                    fe_d    = err_d | (row_d != V_MAX);
                    fc_d    = frame_count + 16'd1;
                    state_d = StWaitVs;
                end
            end
            default: state_d = StWaitVs;
        endcase

        // Re-arming settling skip on enable rise overrides any decrement
        if (enable && !enable_q) begin
            skip_d = SKIP_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StWaitVs;
            skip_q         <= SKIP_INIT;
            col_q          <= '0;
            row_q          <= '0;
            phase_q        <= 1'b0;
            hi_q           <= 8'h00;
            err_q          <= 1'b0;
            first_q        <= 1'b0;
            enable_q       <= 1'b0;
            pixel_out      <= 16'h0000;
            data_valid_out <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            frame_count    <= 16'h0000;
        end else begin
            state_q        <= state_d;
            skip_q         <= skip_d;
            col_q          <= col_d;
            row_q          <= row_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            err_q          <= err_d;
            first_q        <= first_d;
            enable_q       <= enable;
            pixel_out      <= pix_d;
            data_valid_out <= dv_d;
            x_out          <= x_d;
            y_out          <= y_d;
            frame_start    <= fs_d;
            frame_done     <= fd_d;
            frame_error    <= fe_d;
            frame_count    <= fc_d;
        end
    end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Scoreboard bench for camera_pixel_capture on a 4x2 frame geometry.
module tb_camera_pixel_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int SK = 2;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic [15:0]   pixel_out;
    logic          data_valid_out;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic          frame_start;
    logic          frame_done;
    logic          frame_error;
    logic [15:0]   frame_count;

    camera_pixel_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SK),
        .X_W         (XW),
        .Y_W         (YW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .pixel_out      (pixel_out),
        .data_valid_out (data_valid_out),
        .x_out          (x_out),
        .y_out          (y_out),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .frame_error    (frame_error),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   pix;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fs;
    } pix_exp_t;

    typedef struct packed {
        logic        fe;
        logic [15:0] fc;
    } frm_exp_t;

    pix_exp_t pix_q[$];
    frm_exp_t frm_q[$];
    pix_exp_t mon_e;
    frm_exp_t mon_f;

    int vecs    = 0;
    int errs    = 0;
    int strobes = 0;

    // Reference model state: frame_mode 0 = skipped, 1 = captured, 2 = ignored
    int          exp_skip;
    int          frame_mode;
    int          mrow;
    logic        merr;
    logic        mfirst;
    logic [15:0] exp_count;

    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            strobes++;
            vecs++;
            if (pix_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_strobe: got pix=%h x=%0d y=%0d, wanted no strobe",
                         pixel_out, x_out, y_out);
            end else begin
                mon_e = pix_q.pop_front();
                if ({pixel_out, x_out, y_out, frame_start} !== mon_e) begin
                    errs++;
                    $display("FAIL pixel: got pix=%h x=%0d y=%0d fs=%b, wanted pix=%h x=%0d y=%0d fs=%b",
                             pixel_out, x_out, y_out, frame_start,
                             mon_e.pix, mon_e.x, mon_e.y, mon_e.fs);
                end
            end
        end else if (frame_start === 1'b1) begin
            vecs++;
            errs++;
            $display("FAIL frame_start_alone: got frame_start=1 without strobe, wanted 0");
        end
        if (frame_done === 1'b1) begin
            vecs++;
            if (frm_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_frame_done: got frame_done=1, wanted 0");
            end else begin
                mon_f = frm_q.pop_front();
                if ({frame_error, frame_count} !== mon_f) begin
                    errs++;
                    $display("FAIL frame_status: got err=%b count=%0d, wanted err=%b count=%0d",
                             frame_error, frame_count, mon_f.fe, mon_f.fc);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        vecs++;
        if ({pixel_out, data_valid_out, x_out, y_out, frame_start, frame_done, frame_error,
             frame_count} !== '0) begin
            errs++;
            $display("FAIL %s: got pix=%h dv=%b x=%0d y=%0d fs=%b fd=%b fe=%b fc=%0d, wanted all 0",
                     name, pixel_out, data_valid_out, x_out, y_out, frame_start, frame_done,
                     frame_error, frame_count);
        end
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cam_vsync  = 1'b0;
        frame_mode = (exp_skip == 0) ? 1 : 0;
        mrow       = 0;
        merr       = 1'b0;
        mfirst     = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // lat: first pixel is 0xF800 with inline latency checks; rst_at: pulse reset
    task automatic drive_line(input int n, input bit lat, input int rst_at);
        logic [7:0] b;
        logic [7:0] hi;
        pix_exp_t   e;
        hi = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (lat && i == 2) begin
                vecs++;
                if (data_valid_out !== 1'b0) begin
                    errs++;
                    $display("FAIL latency_early: got dv=%b one clk after 2nd byte, wanted 0",
                             data_valid_out);
                end
            end
            if (lat && i == 3) begin
                vecs++;
                if ({data_valid_out, frame_start, pixel_out, x_out, y_out} !==
                    {1'b1, 1'b1, 16'hF800, 10'd0, 9'd0}) begin
                    errs++;
                    $display("FAIL latency_2clk: got dv=%b fs=%b pix=%h x=%0d y=%0d, wanted 1 1 f800 0 0",
                             data_valid_out, frame_start, pixel_out, x_out, y_out);
                end
            end
            if (i == rst_at) rst_n = 1'b0;
            if (i == rst_at + 1) begin
                rst_n = 1'b1;
                pix_q.delete();
                frame_mode = 2;
                exp_skip   = SK;
                exp_count  = 16'd0;
                check_all_zero("reset_midline");
            end
            if (lat && i == 0)      b = 8'hF8;
            else if (lat && i == 1) b = 8'h00;
            else                    b = 8'($urandom_range(0, 255));
            cam_href = 1'b1;
            cam_data = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (frame_mode == 1) begin
                if (i / 2 < H && mrow < V) begin
                    e = {hi, b, XW'(i / 2), YW'(mrow), mfirst};
                    pix_q.push_back(e);
                    mfirst = 1'b0;
                end else begin
                    merr = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        cam_href = 1'b0;
        cam_data = 8'($urandom_range(0, 255));
        if (frame_mode == 1 && n > 0) begin
            if (n % 2 != 0) merr = 1'b1;
            if (n / 2 != H) merr = 1'b1;
            if (n / 2 > 0 && mrow < V) mrow++;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic end_frame();
        frm_exp_t f;
        @(posedge clk); #1;
        cam_vsync = 1'b1;
        if (frame_mode == 1) begin
            exp_count++;
            f.fe = merr | (mrow != V);
            f.fc = exp_count;
            frm_q.push_back(f);
        end else if (frame_mode == 0) begin
            exp_skip--;
        end
        repeat (5) @(posedge clk);
        #1;
        vecs++;
        if (pix_q.size() != 0) begin
            errs++;
            $display("FAIL pixels_missing: got %0d pending, wanted 0", pix_q.size());
        end
        vecs++;
        if (frm_q.size() != 0) begin
            errs++;
            $display("FAIL frame_done_missing: got %0d pending, wanted 0", frm_q.size());
        end
    endtask

    task automatic run_frame(input int l0, input int l1, input int nl);
        begin_frame();
        drive_line(l0, 1'b0, -5);
        if (nl > 1) drive_line(l1, 1'b0, -5);
        end_frame();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        cam_vsync = 1'b1;
        cam_href  = 1'b1;
        cam_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n      = 1'b1;
        cam_href   = 1'b0;
        exp_skip   = SK;
        exp_count  = 16'd0;
        frame_mode = 2;
    endtask

    task automatic test_skip_frames();
        int s0;
        s0 = strobes;
        run_frame(8, 8, 2);
        run_frame(8, 8, 2);
        vecs++;
        if (strobes != s0) begin
            errs++;
            $display("FAIL skip_no_strobes: got %0d strobes, wanted 0", strobes - s0);
        end
        s0 = strobes;
        run_frame(8, 8, 2);
        vecs++;
        if (strobes - s0 != 8) begin
            errs++;
            $display("FAIL first_frame_strobes: got %0d, wanted 8", strobes - s0);
        end
        vecs++;
        if ({frame_count, frame_error} !== {16'd1, 1'b0}) begin
            errs++;
            $display("FAIL first_frame_status: got count=%0d err=%b, wanted 1 0",
                     frame_count, frame_error);
        end
    endtask

    task automatic test_latency();
        begin_frame();
        drive_line(8, 1'b1, -5);
        drive_line(8, 1'b0, -5);
        end_frame();
        vecs++;
        if (frame_count !== 16'd2) begin
            errs++;
            $display("FAIL latency_frame_count: got %0d, wanted 2", frame_count);
        end
    endtask

    task automatic test_odd_line();
        int s0;
        s0 = strobes;
        run_frame(7, 8, 2);
        vecs++;
        if (strobes - s0 != 7) begin
            errs++;
            $display("FAIL odd_line_strobes: got %0d, wanted 7", strobes - s0);
        end
        vecs++;
        if (frame_error !== 1'b1) begin
            errs++;
            $display("FAIL odd_line_error: got %b, wanted 1", frame_error);
        end
        run_frame(8, 8, 2);
        vecs++;
        if (frame_error !== 1'b0) begin
            errs++;
            $display("FAIL clean_after_error: got %b, wanted 0", frame_error);
        end
    endtask

    task automatic test_long_line();
        int s0;
        s0 = strobes;
        run_frame(12, 8, 2);
        vecs++;
        if (strobes - s0 != 8) begin
            errs++;
            $display("FAIL long_line_strobes: got %0d, wanted 8", strobes - s0);
        end
        vecs++;
        if (frame_error !== 1'b1) begin
            errs++;
            $display("FAIL long_line_error: got %b, wanted 1", frame_error);
        end
    endtask

    task automatic test_short_frame();
        run_frame(8, 0, 1);
        vecs++;
        if ({frame_error, frame_count} !== {1'b1, exp_count}) begin
            errs++;
            $display("FAIL short_frame: got err=%b count=%0d, wanted 1 %0d",
                     frame_error, frame_count, exp_count);
        end
    endtask

    task automatic test_reset_midframe();
        begin_frame();
        drive_line(8, 1'b0, 5);
        drive_line(8, 1'b0, -5);
        end_frame();
        run_frame(8, 8, 2);
        run_frame(8, 8, 2);
        run_frame(8, 8, 2);
        vecs++;
        if ({frame_count, frame_error} !== {16'd1, 1'b0}) begin
            errs++;
            $display("FAIL resume_after_reset: got count=%0d err=%b, wanted 1 0",
                     frame_count, frame_error);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, wanted finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        test_reset();
        test_skip_frames();
        test_latency();
        test_odd_line();
        test_long_line();
        test_short_frame();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
